// File: rtl/divider_pkg.sv
// Shared widths, item-word field positions and payload typedefs for the pipelined signed divider.
package divider_pkg;
  localparam int unsigned DW             = 8;
  localparam int unsigned STAGES         = DW;
  localparam int unsigned TW             = 2 * DW;
  localparam int unsigned IW             = DW + 2;
  localparam int unsigned ITEM_DSOR_SIGN = 0;
  localparam int unsigned ITEM_DEND_SIGN = 1;
  localparam int unsigned ITEM_MAG_LSB   = 2;

  typedef logic [TW-1:0] temp_t;
  typedef logic [IW-1:0] item_t;
  typedef logic [DW-1:0] half_t;
endpackage

// File: rtl/divide_step_module.sv
// One registered restoring shift-subtract iteration of the divider pipeline.
// Optional zero-divisor flag forwarding under DIVIDE_ZERO_DETECT_EN.
module divide_step_module
  import divider_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  valid_in,
  input  temp_t temp_in,
  input  item_t item_in,
`ifdef DIVIDE_ZERO_DETECT_EN
  input  logic  zero_in,
  output logic  zero_out,
`endif
  output logic  valid_out,
  output temp_t temp_out,
  output item_t item_out
);

  half_t       dsor;
  logic [DW:0] hi;
  half_t       lo;
  temp_t       temp_next;

  // Shift left by one, then subtract the divisor from the high half when it fits.
  always_comb begin
    dsor = item_in[ITEM_MAG_LSB +: DW];
    hi   = temp_in[TW-1:DW-1];
    lo   = {temp_in[DW-2:0], 1'b0};
    if (hi >= {1'b0, dsor}) begin
      hi    = hi - {1'b0, dsor};
      lo[0] = 1'b1;
    end
    temp_next = {hi[DW-1:0], lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      temp_out  <= '0;
      item_out  <= '0;
`ifdef DIVIDE_ZERO_DETECT_EN
      zero_out  <= 1'b0;
`endif
    end else if (en) begin
      valid_out <= valid_in;
      temp_out  <= temp_next;
      item_out  <= item_in;
`ifdef DIVIDE_ZERO_DETECT_EN
      zero_out  <= zero_in;
`endif
    end
  end

endmodule

// File: rtl/divide_iterate_module.sv
// Iteration pipeline of the 8-bit signed divider: DW shift-subtract stages plus a sign/output stage.
// DIVIDE_ZERO_DETECT_EN enables divide-by-zero detection and result forcing.
module divide_iterate_module
  import divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [TW-1:0] temp_in,
  input  logic [IW-1:0] item_in,
  output logic          out_valid,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          overflow,
  output logic          div_by_zero
);

  temp_t temp_s  [STAGES+1];
  item_t item_s  [STAGES+1];
  logic  valid_s [STAGES+1];
`ifdef DIVIDE_ZERO_DETECT_EN
  logic  zero_s  [STAGES+1];
  assign zero_s[0] = (item_in[ITEM_MAG_LSB +: DW] == '0);
`endif

  assign temp_s[0]  = temp_in;
  assign item_s[0]  = item_in;
  assign valid_s[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    divide_step_module u_step (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .valid_in  (valid_s[k]),
      .temp_in   (temp_s[k]),
      .item_in   (item_s[k]),
`ifdef DIVIDE_ZERO_DETECT_EN
      .zero_in   (zero_s[k]),
      .zero_out  (zero_s[k+1]),
`endif
      .valid_out (valid_s[k+1]),
      .temp_out  (temp_s[k+1]),
      .item_out  (item_s[k+1])
    );
  end

  half_t qm;
  half_t rm;
  logic  dend_neg;
  logic  quot_neg;

  always_comb begin
    qm       = temp_s[STAGES][DW-1:0];
    rm       = temp_s[STAGES][TW-1:DW];
    dend_neg = item_s[STAGES][ITEM_DEND_SIGN];
    quot_neg = item_s[STAGES][ITEM_DEND_SIGN] ^ item_s[STAGES][ITEM_DSOR_SIGN];
  end

  // Sign application; results hold across bubbles so the last answer stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
`ifdef DIVIDE_ZERO_DETECT_EN
      div_by_zero <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= valid_s[STAGES];
      if (valid_s[STAGES]) begin
        quotient  <= quot_neg ? -qm : qm;
        remainder <= dend_neg ? -rm : rm;
        overflow  <= (qm == half_t'(1 << (DW - 1))) && !quot_neg;
`ifdef DIVIDE_ZERO_DETECT_EN
        div_by_zero <= zero_s[STAGES];
        if (zero_s[STAGES]) begin
          quotient <= '0;
          overflow <= 1'b0;
        end
`endif
      end
    end
  end

`ifndef DIVIDE_ZERO_DETECT_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divide_iterate_module.sv
// Directed and streaming checks for divide_iterate_module; expectations follow DIVIDE_ZERO_DETECT_EN.
module tb_divide_iterate_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] temp_in;
  logic [9:0]  item_in;
  logic        out_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  divide_iterate_module dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_valid    (in_valid),
    .temp_in     (temp_in),
    .item_in     (item_in),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer division on magnitudes, then signs.
  task automatic model(input logic [7:0] dm, input logic [7:0] vm, input logic sd, input logic ss,
                       output logic [7:0] q, output logic [7:0] r, output logic o, output logic d);
    int qm, rm;
    if (vm == 8'd0) begin
      qm = 255;
      rm = int'(dm);
    end else begin
      qm = int'(dm) / int'(vm);
      rm = int'(dm) % int'(vm);
    end
    q = 8'((sd ^ ss) ? -qm : qm);
    r = 8'(sd ? -rm : rm);
    o = (qm == 128) && !(sd ^ ss);
    d = 1'b0;
`ifdef DIVIDE_ZERO_DETECT_EN
    if (vm == 8'd0) begin
      q = 8'h00;
      o = 1'b0;
      d = 1'b1;
    end
`endif
  endtask

  task automatic run_one(input string tag, input logic [15:0] t, input logic [9:0] it,
                         input logic [7:0] eq, input logic [7:0] er, input logic eo, input logic ed);
    temp_in  = t;
    item_in  = it;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check({tag, ".early"}, 16'(out_valid), 16'h0);
    step();
    check({tag, ".valid"}, 16'(out_valid), 16'h1);
    check({tag, ".q"}, 16'(quotient), 16'(eq));
    check({tag, ".r"}, 16'(remainder), 16'(er));
    check({tag, ".ovf"}, 16'(overflow), 16'(eo));
    check({tag, ".dbz"}, 16'(div_by_zero), 16'(ed));
  endtask

  logic [7:0] sq_q[$];
  logic [7:0] sq_r[$];
  logic       sq_o[$];
  logic       sq_d[$];
  int         sq_c[$];
  int         sq_s[$];

  logic [7:0] dm, vm, eq, er;
  logic       sd, ss, eo, ed;
  logic       en_now, pv;
  logic [7:0] pq, pr;
  int         cyc, stalls, issued, got, c0, s0;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    temp_in  = '0;
    item_in  = '0;
    #1;
    check("reset.valid", 16'(out_valid), 16'h0);
    check("reset.q", 16'(quotient), 16'h0);
    check("reset.r", 16'(remainder), 16'h0);
    check("reset.ovf", 16'(overflow), 16'h0);
    check("reset.dbz", 16'(div_by_zero), 16'h0);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    step();

    run_one("p100_p7", 16'h0064, {8'd7, 2'b00}, 8'h0E, 8'h02, 1'b0, 1'b0);
    run_one("n100_p7", 16'h0064, {8'd7, 2'b10}, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_one("p100_n7", 16'h0064, {8'd7, 2'b01}, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_one("n100_n7", 16'h0064, {8'd7, 2'b11}, 8'h0E, 8'hFE, 1'b0, 1'b0);
    run_one("n128_n1", 16'h0080, {8'h01, 2'b11}, 8'h80, 8'h00, 1'b1, 1'b0);
    run_one("n128_p1", 16'h0080, {8'h01, 2'b10}, 8'h80, 8'h00, 1'b0, 1'b0);
    run_one("p127_n128", 16'h007F, {8'h80, 2'b01}, 8'h00, 8'h7F, 1'b0, 1'b0);
`ifdef DIVIDE_ZERO_DETECT_EN
    run_one("p50_z", 16'h0032, 10'h000, 8'h00, 8'h32, 1'b0, 1'b1);
    run_one("n50_z", 16'h0032, 10'h002, 8'h00, 8'hCE, 1'b0, 1'b1);
`else
    run_one("p50_z", 16'h0032, 10'h000, 8'hFF, 8'h32, 1'b0, 1'b0);
    run_one("n50_z", 16'h0032, 10'h002, 8'h01, 8'hCE, 1'b0, 1'b0);
`endif

    // Back-to-back stream with a 3-cycle stall; garbage offered during the stall must be ignored.
    cyc = 0; stalls = 0; issued = 0; got = 0;
    pv = out_valid; pq = quotient; pr = remainder;
    for (int c = 0; c < 60; c++) begin
      en_now = !(c >= 8 && c < 11);
      en = en_now;
      if (!en_now) begin
        in_valid = 1'b1;
        temp_in  = 16'h0055;
        item_in  = 10'h3FF;
        stalls++;
      end else if (issued < 20) begin
        dm = 8'($urandom_range(0, 128));
        vm = 8'($urandom_range(0, 128));
        sd = 1'($urandom);
        ss = 1'($urandom);
        temp_in  = {8'h00, dm};
        item_in  = {vm, sd, ss};
        in_valid = 1'b1;
        model(dm, vm, sd, ss, eq, er, eo, ed);
        sq_q.push_back(eq); sq_r.push_back(er); sq_o.push_back(eo); sq_d.push_back(ed);
        sq_c.push_back(cyc); sq_s.push_back(stalls);
        issued++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
      if (!en_now) begin
        check("stall.valid", 16'(out_valid), 16'(pv));
        check("stall.q", 16'(quotient), 16'(pq));
        check("stall.r", 16'(remainder), 16'(pr));
      end else if (out_valid) begin
        if (sq_q.size() == 0) begin
          check("stream.unexpected", 16'(out_valid), 16'h0);
        end else begin
          c0 = sq_c.pop_front();
          s0 = sq_s.pop_front();
          check("stream.q", 16'(quotient), 16'(sq_q.pop_front()));
          check("stream.r", 16'(remainder), 16'(sq_r.pop_front()));
          check("stream.ovf", 16'(overflow), 16'(sq_o.pop_front()));
          check("stream.dbz", 16'(div_by_zero), 16'(sq_d.pop_front()));
          check("stream.latency", 16'((cyc - c0) - (stalls - s0)), 16'd9);
          got++;
        end
      end
      pv = out_valid; pq = quotient; pr = remainder;
    end
    en = 1'b1;
    check("stream.count", 16'(got), 16'd20);

    // Five operations in flight, then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) begin
      temp_in  = {8'h00, 8'(8'd90 + 8'(i))};
      item_in  = {8'd3, 2'b10};
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", 16'(out_valid), 16'h0);
    check("midrst.q", 16'(quotient), 16'h0);
    check("midrst.r", 16'(remainder), 16'h0);
    check("midrst.ovf", 16'(overflow), 16'h0);
    check("midrst.dbz", 16'(div_by_zero), 16'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("postrst.idle", 16'(out_valid), 16'h0);
    end
    run_one("postrst", 16'h0064, {8'd7, 2'b00}, 8'h0E, 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
